// File: rtl/mux_arbitro_rr.sv
// -----------------------------------------------------------------------------
// mux_arbitro_rr
//
// Purpose:
//   N-channel arbitrating multiplexer. Each cycle it selects one requesting
//   source FIFO (round-robin or fixed priority), pops it, and registers the
//   popped word, its channel index and a valid flag toward the downstream FIFO.
//   A granted channel may keep the grant for up to BURST_LEN consecutive words.
//
// Handshake:
//   valid_in[i] means source FIFO i holds a word. pop[i] is the read strobe; a
//   word moves out of FIFO i exactly in a cycle where valid_in[i] && pop[i].
//   pop never asserts for a channel whose valid_in bit is low, so the source
//   FIFO never sees a read while empty. Downstream there is no ready signal:
//   pausa (almost-full) stops new pops, and valid_out marks each new word on
//   salida_mux for exactly one cycle.
//
// Ports:
//   clk           in   rising-edge clock
//   reset_L       in   asynchronous active-low reset
//   enb           in   block enable; low clears outputs and idles the arbiter
//   pausa         in   downstream almost-full; freezes the arbiter, no pops
//   valid_in      in   [NUM_CH] per-channel "word available"
//   entradas_mux  in   [NUM_CH*DATA_WIDTH] channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   pop           out  [NUM_CH] one-hot or zero read strobe (combinational)
//   salida_mux    out  [DATA_WIDTH] registered selected word
//   valid_out     out  registered; salida_mux carries a new word this cycle
//   canal_out     out  [CH_W] registered channel index of salida_mux
//   estado_dbg    out  [2] current arbiter state (0 INACTIVO, 1 ARBITRA, 2 RAFAGA)
// -----------------------------------------------------------------------------
module mux_arbitro_rr #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CH     = 4,
    parameter int BURST_LEN  = 1,
    parameter int MODO       = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset_L,
    input  logic                         enb,
    input  logic                         pausa,
    input  logic [NUM_CH-1:0]            valid_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] entradas_mux,
    output logic [NUM_CH-1:0]            pop,
    output logic [DATA_WIDTH-1:0]        salida_mux,
    output logic                         valid_out,
    output logic [CH_W-1:0]              canal_out,
    output logic [1:0]                   estado_dbg
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_UNO   = CNT_W'(1);
    localparam logic [CH_W-1:0]  PTR_RST   = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        ARBITRA  = 2'd1,
        RAFAGA   = 2'd2
    } estado_t;

    estado_t           estado, estado_n;
    logic [CH_W-1:0]   ptr, ptr_n;        // last channel that finished a grant
    logic [CH_W-1:0]   actual, actual_n;  // channel owning the current burst
    logic [CNT_W-1:0]  cnt, cnt_n;        // words already given in this burst

    // Arbitration results
    logic [CH_W-1:0]   scan_base;
    logic [CH_W-1:0]   cand;
    logic              rr_found;
    logic [CH_W-1:0]   rr_idx;
    logic              fp_found;
    logic [CH_W-1:0]   fp_idx;
    logic              hold;
    logic              win_found;
    logic [CH_W-1:0]   win_idx;
    logic              go;

    logic [DATA_WIDTH-1:0] dato_canal [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign dato_canal[g] = entradas_mux[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign estado_dbg = estado;

    // -------------------------------------------------------------------------
    // Arbitration (combinational, so a valid_in change is seen the same cycle)
    // -------------------------------------------------------------------------
    always_comb begin
        // While a burst is ending, the scan starts after the burst owner; this
        // is the same pointer value the burst end will write into ptr.
        scan_base = (estado == RAFAGA) ? actual : ptr;

        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(scan_base) + k) % NUM_CH);
            if (!rr_found && valid_in[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end

        // Descending scan: the lowest requesting index is the last one written.
        fp_found = 1'b0;
        fp_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (valid_in[i]) begin
                fp_found = 1'b1;
                fp_idx   = CH_W'(i);
            end
        end

        hold = (estado == RAFAGA) && valid_in[actual] && (cnt < BURST_MAX);

        if (hold) begin
            win_found = 1'b1;
            win_idx   = actual;
        end else if (MODO == 1) begin
            win_found = fp_found;
            win_idx   = fp_idx;
        end else begin
            win_found = rr_found;
            win_idx   = rr_idx;
        end

        go = reset_L && enb && !pausa && (estado != INACTIVO) && win_found;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            estado <= INACTIVO;
            ptr    <= PTR_RST;
            actual <= '0;
            cnt    <= '0;
        end else begin
            estado <= estado_n;
            ptr    <= ptr_n;
            actual <= actual_n;
            cnt    <= cnt_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        estado_n = estado;
        ptr_n    = ptr;
        actual_n = actual;
        cnt_n    = cnt;

        if (!enb) begin
            // ptr survives a disable so arbitration resumes where it left off.
            estado_n = INACTIVO;
            cnt_n    = '0;
        end else if (pausa) begin
            // Everything frozen: a paused burst resumes with the same count.
        end else begin
            case (estado)
                INACTIVO: begin
                    estado_n = ARBITRA;
                end
                ARBITRA: begin
                    if (go) begin
                        actual_n = win_idx;
                        cnt_n    = CNT_UNO;
                        if (BURST_LEN > 1) begin
                            estado_n = RAFAGA;
                        end else begin
                            ptr_n = win_idx;
                        end
                    end
                end
                RAFAGA: begin
                    if (hold) begin
                        cnt_n = cnt + CNT_UNO;
                        if (cnt + CNT_UNO == BURST_MAX) begin
                            ptr_n    = actual;
                            estado_n = ARBITRA;
                        end
                    end else begin
                        // Burst owner dropped its request: close the burst and
                        // grant the next winner in this same cycle.
                        ptr_n = actual;
                        if (go) begin
                            actual_n = win_idx;
                            cnt_n    = CNT_UNO;
                        end else begin
                            estado_n = ARBITRA;
                        end
                    end
                end
                default: begin
                    estado_n = INACTIVO;
                    cnt_n    = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: combinational pop strobe and registered word/channel/valid
    // -------------------------------------------------------------------------
    always_comb begin
        pop = '0;
        if (go) begin
            pop[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            salida_mux <= '0;
            valid_out  <= 1'b0;
            canal_out  <= '0;
        end else if (!enb) begin
            salida_mux <= '0;
            valid_out  <= 1'b0;
            canal_out  <= '0;
        end else if (go) begin
            salida_mux <= dato_canal[win_idx];
            valid_out  <= 1'b1;
            canal_out  <= win_idx;
        end else begin
            valid_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arbitro_rr.sv
// -----------------------------------------------------------------------------
// tb_mux_arbitro_rr
//
// Three instances share one stimulus stream:
//   inst 0: BURST_LEN=1, round-robin
//   inst 1: BURST_LEN=3, round-robin
//   inst 2: BURST_LEN=2, fixed priority
// A behavioural model per instance tracks "active", the round-robin pointer
// and an optional open burst (owner, words given) and predicts pop and the
// registered outputs for every cycle.
// -----------------------------------------------------------------------------
module tb_mux_arbitro_rr;

  localparam int NC = 4;
  localparam int NI = 3;

  // clock / reset
  logic clk;
  logic reset_L;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // shared inputs
  logic        enb;
  logic        pausa;
  logic [3:0]  valid_in;
  logic [3:0]  dat [NC];
  logic [15:0] entradas_mux;
  assign entradas_mux = {dat[3], dat[2], dat[1], dat[0]};

  // per-instance outputs
  logic [3:0] pop0, pop1, pop2;
  logic [3:0] sal0, sal1, sal2;
  logic       val0, val1, val2;
  logic [1:0] can0, can1, can2;
  logic [1:0] est0, est1, est2;

  logic [3:0] pop_v [NI];
  logic [3:0] sal_v [NI];
  logic       val_v [NI];
  logic [1:0] can_v [NI];
  assign pop_v[0] = pop0; assign pop_v[1] = pop1; assign pop_v[2] = pop2;
  assign sal_v[0] = sal0; assign sal_v[1] = sal1; assign sal_v[2] = sal2;
  assign val_v[0] = val0; assign val_v[1] = val1; assign val_v[2] = val2;
  assign can_v[0] = can0; assign can_v[1] = can1; assign can_v[2] = can2;

  mux_arbitro_rr #(.DATA_WIDTH(4), .NUM_CH(4), .BURST_LEN(1), .MODO(0)) u_rr1 (
    .clk(clk), .reset_L(reset_L), .enb(enb), .pausa(pausa),
    .valid_in(valid_in), .entradas_mux(entradas_mux), .pop(pop0),
    .salida_mux(sal0), .valid_out(val0), .canal_out(can0), .estado_dbg(est0)
  );

  mux_arbitro_rr #(.DATA_WIDTH(4), .NUM_CH(4), .BURST_LEN(3), .MODO(0)) u_rr3 (
    .clk(clk), .reset_L(reset_L), .enb(enb), .pausa(pausa),
    .valid_in(valid_in), .entradas_mux(entradas_mux), .pop(pop1),
    .salida_mux(sal1), .valid_out(val1), .canal_out(can1), .estado_dbg(est1)
  );

  mux_arbitro_rr #(.DATA_WIDTH(4), .NUM_CH(4), .BURST_LEN(2), .MODO(1)) u_fp2 (
    .clk(clk), .reset_L(reset_L), .enb(enb), .pausa(pausa),
    .valid_in(valid_in), .entradas_mux(entradas_mux), .pop(pop2),
    .salida_mux(sal2), .valid_out(val2), .canal_out(can2), .estado_dbg(est2)
  );

  // scoreboard counters
  int n_vec;
  int n_err;

  // reference model state
  logic [3:0] exp_q [$];
  bit         m_active [NI];
  int         m_ptr    [NI];
  bit         m_inb    [NI];
  int         m_bch    [NI];
  int         m_bcnt   [NI];
  logic [3:0] m_sal    [NI];
  logic       m_val    [NI];
  logic [1:0] m_can    [NI];
  logic [3:0] exp_pop  [NI];

  function automatic int bl_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit fixed_of(input int k);
    return (k == 2);
  endfunction

  // Winner among requesters by the instance's arbitration rule, -1 if none.
  function automatic int pick(input int k, input logic [3:0] req, input int p);
    if (fixed_of(k)) begin
      for (int i = 0; i < NC; i++)
        if (req[i]) return i;
    end else begin
      for (int j = 1; j <= NC; j++)
        if (req[(p + j) % NC]) return (p + j) % NC;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_active[k] = 1'b0;
      m_ptr[k]    = NC - 1;
      m_inb[k]    = 1'b0;
      m_bch[k]    = 0;
      m_bcnt[k]   = 0;
      m_sal[k]    = '0;
      m_val[k]    = 1'b0;
      m_can[k]    = '0;
      exp_pop[k]  = '0;
    end
  endtask

  // One clock cycle of the model with the current inputs: sets exp_pop and
  // the output values expected after the coming rising edge.
  task automatic model_cycle(input int k);
    int w;
    int bl;
    bl = bl_of(k);
    w  = -1;
    exp_pop[k] = '0;
    if (!enb) begin
      m_active[k] = 1'b0;
      m_inb[k]    = 1'b0;
      m_sal[k]    = '0;
      m_val[k]    = 1'b0;
      m_can[k]    = '0;
      return;
    end
    if (!m_active[k]) begin
      if (!pausa) m_active[k] = 1'b1;
      m_val[k] = 1'b0;
      return;
    end
    if (pausa) begin
      m_val[k] = 1'b0;
      return;
    end
    if (m_inb[k] && valid_in[m_bch[k]]) begin
      w = m_bch[k];
      m_bcnt[k] = m_bcnt[k] + 1;
      if (m_bcnt[k] == bl) begin
        m_inb[k] = 1'b0;
        m_ptr[k] = w;
      end
    end else begin
      if (m_inb[k]) begin
        m_ptr[k] = m_bch[k];
        m_inb[k] = 1'b0;
      end
      w = pick(k, valid_in, m_ptr[k]);
      if (w >= 0) begin
        if (bl > 1) begin
          m_inb[k]  = 1'b1;
          m_bch[k]  = w;
          m_bcnt[k] = 1;
        end else begin
          m_ptr[k] = w;
        end
      end
    end
    if (w >= 0) begin
      exp_pop[k][w] = 1'b1;
      m_sal[k] = dat[w];
      m_val[k] = 1'b1;
      m_can[k] = 2'(w);
    end else begin
      m_val[k] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h t=%0t", tag, k, obs, expv, $time);
    end
  endtask

  task automatic chk_regs();
    for (int k = 0; k < NI; k++) begin
      chk("salida_mux", k, 32'(sal_v[k]), 32'(m_sal[k]));
      chk("valid_out",  k, 32'(val_v[k]), 32'(m_val[k]));
      chk("canal_out",  k, 32'(can_v[k]), 32'(m_can[k]));
    end
  endtask

  // driver: inputs already applied at a falling edge; check pop, clock once,
  // then check the registered outputs at the next falling edge.
  task automatic step();
    #1;
    for (int k = 0; k < NI; k++) begin
      model_cycle(k);
      exp_q.push_back(exp_pop[k]);
      chk("pop", k, 32'(pop_v[k]), 32'(exp_q.pop_front()));
      chk("pop_onehot0", k, 32'($onehot0(pop_v[k])), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    chk_regs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset asserted between rising edges: outputs and pop clear at once.
  task automatic mid_reset();
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) chk("pop_in_reset", k, 32'(pop_v[k]), 32'd0);
    chk_regs();
    @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_L  = 1'b0;
    enb      = 1'b0;
    pausa    = 1'b0;
    valid_in = 4'b0000;
    for (int i = 0; i < NC; i++) dat[i] = '0;
    model_reset();

    // reset state
    #2;
    for (int k = 0; k < NI; k++) chk("pop_reset", k, 32'(pop_v[k]), 32'd0);
    chk_regs();
    @(negedge clk);

    // all channels requesting, data A,B,C,D
    reset_L  = 1'b1;
    enb      = 1'b1;
    valid_in = 4'b1111;
    dat[0] = 4'hA; dat[1] = 4'hB; dat[2] = 4'hC; dat[3] = 4'hD;
    steps(8);

    // alternate 0 and 2
    valid_in = 4'b0101;
    steps(6);

    // two requesters, then channel 1 drops, then returns
    valid_in = 4'b0011;
    steps(8);
    valid_in = 4'b0001;
    steps(2);
    valid_in = 4'b0011;
    steps(2);

    // pause mid-burst for 3 cycles
    valid_in = 4'b0011;
    steps(2);
    pausa = 1'b1;
    steps(3);
    pausa = 1'b0;
    steps(4);

    // disable while producing, then disable together with pause
    valid_in = 4'b1111;
    steps(2);
    enb = 1'b0;
    steps(1);
    pausa = 1'b1;
    steps(1);
    enb   = 1'b1;
    pausa = 1'b0;
    steps(5);

    // fixed-priority pattern and no requesters
    valid_in = 4'b1010;
    steps(6);
    valid_in = 4'b0000;
    steps(3);

    // randomized traffic with a reset in the middle
    for (int it = 0; it < 400; it++) begin
      valid_in = 4'($urandom_range(0, 15));
      for (int i = 0; i < NC; i++) dat[i] = 4'($urandom_range(0, 15));
      pausa = ($urandom_range(0, 4) == 0);
      enb   = ($urandom_range(0, 9) != 0);
      if (it == 200) mid_reset();
      step();
    end

    // reset mid-burst, then lowest requester wins first
    enb      = 1'b1;
    pausa    = 1'b0;
    valid_in = 4'b0110;
    steps(3);
    mid_reset();
    steps(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arbitro_rr.md
Name: mux_arbitro_rr

Overview:
- N-channel, parametrised successor of the 4:1 enable mux; selects one requesting channel per cycle with round-robin (or fixed-priority) arbitration.
- Pops the winning channel's source FIFO and registers its word, channel index and valid flag toward the downstream FIFO.
- Honours a downstream pause (almost-full) and supports bursts of up to BURST_LEN words per grant.

Parameters:
- DATA_WIDTH, 4, bits per data word.
- NUM_CH, 4, number of input channels (2..16).
- BURST_LEN, 1, maximum consecutive words granted to one channel before arbitration moves on (1..15).
- MODO, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous active-low reset.
- enb  input  1  block enable.
- pausa  input  1  downstream almost-full; blocks new grants.
- valid_in  input  NUM_CH  bit i = channel i has a word (source FIFO not empty).
- entradas_mux  input  NUM_CH*DATA_WIDTH  channel i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- pop  output  NUM_CH  one-hot (or zero) combinational read strobe to the source FIFOs.
- salida_mux  output  DATA_WIDTH  registered selected word.
- valid_out  output  1  registered; salida_mux is a new word this cycle.
- canal_out  output  CH_W  registered index of the channel that produced salida_mux; CH_W = max(1,$clog2(NUM_CH)).

Behaviour:
- Reset (reset_L=0, asynchronous):
  - salida_mux=0, valid_out=0, canal_out=0.
  - Grant pointer ptr=NUM_CH-1, so channel 0 is checked first.
  - Burst counter cnt=0; state=INACTIVO.
  - pop=0 while in reset.
- States:
  - INACTIVO: no grants.
    - Enter on reset or when enb=0.
    - Leave for ARBITRA when enb=1.
  - ARBITRA: picks the winner.
    - Round-robin: first i with valid_in[i]=1, scanning from ptr+1 with wrap modulo NUM_CH.
    - Fixed priority: lowest i with valid_in[i]=1.
    - A grant loads actual=i and cnt=1, then goes to RAFAGA if BURST_LEN>1; otherwise ptr=i and stays in ARBITRA.
  - RAFAGA: channel actual keeps the grant while valid_in[actual]=1 and cnt<BURST_LEN; cnt increments per word.
    - On cnt reaching BURST_LEN, or valid_in[actual]=0: ptr=actual, return to ARBITRA.
    - Re-arbitration happens in the same cycle, with no idle bubble.
- Pop:
  - Asserted combinationally in the cycle of a grant: pop[i]=1 iff state≠INACTIVO, enb=1, pausa=0, reset_L=1, valid_in[i]=1 and i is the current winner.
  - At most one pop bit is set per cycle.
- Latency and output registers: one cycle.
  - On a pop cycle, the next edge registers salida_mux=entradas_mux[i], canal_out=i, valid_out=1.
  - Otherwise valid_out=0 and salida_mux/canal_out hold their previous values.
- pausa=1: pop=0 and valid_out=0 next cycle. State, ptr and cnt are frozen; a paused burst resumes with the same channel and count.
- enb=0:
  - pop=0; next edge salida_mux=0, valid_out=0, canal_out=0.
  - State goes to INACTIVO, cnt=0; ptr is retained.
- No valid_in bits set: no pop, valid_out=0, ptr unchanged.
- Single requester: it is granted every cycle, whatever ptr is.
- Wrap-around: round-robin scan after ptr=NUM_CH-1 starts at channel 0.
- Simultaneous events: pausa and enb=0 in the same cycle resolve as enb=0. A valid_in change is seen in the same cycle (combinational arbitration).
- Reset mid-burst: immediate clear, including pop. The first grant after reset goes to the lowest requesting channel.

Test Plan:
- Reset then all valid_in=4'b1111, entradas {D,C,B,A}, BURST_LEN=1, MODO=0 -> pop cycles 1,2,4,8,1; valid_out=1 every cycle from 1 cycle later; salida_mux A,B,C,D,A; canal_out 0,1,2,3,0.
- valid_in=4'b0101 -> grants alternate channel 0 and 2; channels 1 and 3 never popped.
- BURST_LEN=3, valid_in=4'b0011 held -> pop pattern 1,1,1,2,2,2,1; channel 1 drops valid after 1 word -> immediate switch back to channel 0, no gap in valid_out.
- pausa=1 for 3 cycles mid-burst (cnt=2) -> pop=0 and valid_out=0 for 3 cycles; after release 1 more word from the same channel, then next channel.
- enb=0 while salida_mux=4'hA -> next cycle salida_mux=0, valid_out=0, pop=0; enb=1 resumes from ptr+1.
- MODO=1, valid_in=4'b1010 -> only channel 1 popped while it requests. reset_L asserted between clock edges -> outputs 0 immediately, pop=0.
